// File: rtl/outbuf_vc_fifo.sv
// Output buffer for one router output port: NUM_VC virtual-channel FIFOs, written by the
// crossbar only for the VC in internal phase and drained to the link only for the VC in external phase.
module outbuf_vc_fifo #(
    parameter int DATA_W = 64,
    parameter int NUM_VC = 2,
    parameter int DEPTH  = 2,
    localparam int VC_W  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enq,
    input  logic [VC_W-1:0]         enq_vc,
    input  logic [DATA_W-1:0]       d_in,
    input  logic [VC_W-1:0]         int_vc,
    input  logic [VC_W-1:0]         ext_vc,
    output logic                    enq_ack,
    output logic                    so,
    input  logic [NUM_VC-1:0]       ro,
    output logic [DATA_W-1:0]       d_out,
    output logic [NUM_VC-1:0]       full,
    output logic [NUM_VC-1:0]       empty,
    output logic [NUM_VC*CNT_W-1:0] count,
    output logic                    drop_err
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem  [NUM_VC][DEPTH];
    logic [PTR_W-1:0]  wptr [NUM_VC];
    logic [PTR_W-1:0]  rptr [NUM_VC];
    logic [CNT_W-1:0]  cnt  [NUM_VC];
    logic [NUM_VC-1:0] wr_sel;
    logic [NUM_VC-1:0] rd_sel;
    logic              drop_hit;

    always_comb begin
        full  = '0;
        empty = '0;
        count = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            full[v]  = (cnt[v] == FULL_CNT);
            empty[v] = (cnt[v] == '0);
            count[v*CNT_W +: CNT_W] = cnt[v];
        end
    end

    // Handshakes: a write transfers on the rising edge where enq_ack is high; a flit leaves on the
    // rising edge where so is high. d_out shows the ext VC head whenever it is non-empty, regardless of ro.
    // Per-VC loops keep out-of-range int_vc/ext_vc from selecting anything.
    always_comb begin
        wr_sel   = '0;
        rd_sel   = '0;
        drop_hit = 1'b0;
        d_out    = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (enq && enq_vc == VC_W'(v) && int_vc == VC_W'(v)) begin
                wr_sel[v] = reset_n & ~full[v];
                drop_hit  = full[v];
            end
            if (ext_vc == VC_W'(v) && !empty[v]) begin
                rd_sel[v] = reset_n & ro[v];
                d_out     = mem[v][rptr[v]];
            end
        end
        enq_ack = |wr_sel;
        so      = |rd_sel;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_err <= 1'b0;
            for (int v = 0; v < NUM_VC; v++) begin
                wptr[v] <= '0;
                rptr[v] <= '0;
                cnt[v]  <= '0;
                for (int e = 0; e < DEPTH; e++) begin
                    mem[v][e] <= '0;
                end
            end
        end else begin
            if (drop_hit) begin
                drop_err <= 1'b1;
            end
            for (int v = 0; v < NUM_VC; v++) begin
                if (wr_sel[v]) begin
                    mem[v][wptr[v]] <= d_in;
                    wptr[v] <= (wptr[v] == LAST_PTR) ? '0 : wptr[v] + PTR_W'(1);
                end
                if (rd_sel[v]) begin
                    rptr[v] <= (rptr[v] == LAST_PTR) ? '0 : rptr[v] + PTR_W'(1);
                end
                // Simultaneous write and send leave the occupancy unchanged.
                if (wr_sel[v] && !rd_sel[v]) begin
                    cnt[v] <= cnt[v] + CNT_W'(1);
                end else if (!wr_sel[v] && rd_sel[v]) begin
                    cnt[v] <= cnt[v] - CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_outbuf_vc_fifo.sv
// Bench for outbuf_vc_fifo: a 2-VC/depth-2 instance and a 1-VC/depth-3 instance share clock and reset;
// flits are pushed to per-VC expected queues when accepted and checked in order as the link sends them.
module tb_outbuf_vc_fifo;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic        a_enq, a_enq_vc, a_int_vc, a_ext_vc;
    logic [63:0] a_d_in, a_dout;
    logic [1:0]  a_ro, a_full, a_empty;
    logic        a_enq_ack, a_so, a_drop;
    logic [3:0]  a_count;

    logic        b_enq, b_enq_vc, b_int_vc, b_ext_vc;
    logic [63:0] b_d_in, b_dout;
    logic [0:0]  b_ro, b_full, b_empty;
    logic        b_enq_ack, b_so, b_drop;
    logic [1:0]  b_count;

    outbuf_vc_fifo #(.DATA_W(64), .NUM_VC(2), .DEPTH(2)) u_dut_a (
        .clk(clk), .reset_n(rst_n), .enq(a_enq), .enq_vc(a_enq_vc), .d_in(a_d_in),
        .int_vc(a_int_vc), .ext_vc(a_ext_vc), .enq_ack(a_enq_ack), .so(a_so), .ro(a_ro),
        .d_out(a_dout), .full(a_full), .empty(a_empty), .count(a_count), .drop_err(a_drop)
    );

    outbuf_vc_fifo #(.DATA_W(64), .NUM_VC(1), .DEPTH(3)) u_dut_b (
        .clk(clk), .reset_n(rst_n), .enq(b_enq), .enq_vc(b_enq_vc), .d_in(b_d_in),
        .int_vc(b_int_vc), .ext_vc(b_ext_vc), .enq_ack(b_enq_ack), .so(b_so), .ro(b_ro),
        .d_out(b_dout), .full(b_full), .empty(b_empty), .count(b_count), .drop_err(b_drop)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [63:0] exp_q0[$];
    logic [63:0] exp_q1[$];
    logic [63:0] exp_qb[$];
    int rx_b = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Scoreboard: every send must match the head of the expected queue of the sending VC.
    always @(negedge clk) begin
        if (rst_n && a_so) begin
            if (a_ext_vc == 1'b0) begin
                if (exp_q0.size() == 0) check_eq("a_so_unexpected_vc0", 64'(a_so), 64'd0);
                else check_eq("a_dout_vc0", a_dout, exp_q0.pop_front());
            end else begin
                if (exp_q1.size() == 0) check_eq("a_so_unexpected_vc1", 64'(a_so), 64'd0);
                else check_eq("a_dout_vc1", a_dout, exp_q1.pop_front());
            end
        end
        if (rst_n && b_so) begin
            if (exp_qb.size() == 0) check_eq("b_so_unexpected", 64'(b_so), 64'd0);
            else begin
                check_eq("b_dout", b_dout, exp_qb.pop_front());
                rx_b++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int next;
        rst_n = 1'b0;
        a_enq = 1'b1; a_enq_vc = 1'b0; a_int_vc = 1'b0; a_ext_vc = 1'b0; a_d_in = 64'h1; a_ro = 2'b11;
        b_enq = 1'b0; b_enq_vc = 1'b0; b_int_vc = 1'b0; b_ext_vc = 1'b0; b_d_in = 64'h0; b_ro = 1'b0;
        #2;
        check_eq("rst_enq_ack", 64'(a_enq_ack), 64'd0);
        check_eq("rst_so", 64'(a_so), 64'd0);
        check_eq("rst_dout", a_dout, 64'd0);
        check_eq("rst_empty", 64'(a_empty), 64'h3);
        check_eq("rst_full", 64'(a_full), 64'h0);
        check_eq("rst_count", 64'(a_count), 64'h0);
        check_eq("rst_drop", 64'(a_drop), 64'd0);
        a_enq = 1'b0; a_ro = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Phase gating: write to VC1 while VC0 is internal is ignored.
        a_enq = 1'b1; a_enq_vc = 1'b1; a_int_vc = 1'b0; a_d_in = 64'hA5; a_ext_vc = 1'b0; a_ro = 2'b00;
        settle();
        check_eq("t2_enq_ack", 64'(a_enq_ack), 64'd0);
        tick();
        a_enq = 1'b0;
        settle();
        check_eq("t2_count_vc1", 64'(a_count[3:2]), 64'd0);
        check_eq("t2_drop", 64'(a_drop), 64'd0);

        // Fill VC0 to full, overflow once, then drain in order.
        a_enq_vc = 1'b0; a_int_vc = 1'b0; a_ext_vc = 1'b1;
        for (int i = 0; i < 2; i++) begin
            a_enq = 1'b1; a_d_in = (i == 0) ? 64'h11 : 64'h22;
            settle();
            check_eq("t3_enq_ack", 64'(a_enq_ack), 64'd1);
            exp_q0.push_back(a_d_in);
            tick();
        end
        a_d_in = 64'h33;
        settle();
        check_eq("t3_full0", 64'(a_full[0]), 64'd1);
        check_eq("t3_count0", 64'(a_count[1:0]), 64'd2);
        check_eq("t3_ovf_ack", 64'(a_enq_ack), 64'd0);
        tick();
        a_enq = 1'b0;
        settle();
        check_eq("t3_drop", 64'(a_drop), 64'd1);
        a_ext_vc = 1'b0; a_ro = 2'b01;
        for (int i = 0; i < 2; i++) begin
            settle();
            check_eq("t3_so", 64'(a_so), 64'd1);
            tick();
        end
        a_ro = 2'b00;
        settle();
        check_eq("t3_so_done", 64'(a_so), 64'd0);
        check_eq("t3_empty0", 64'(a_empty[0]), 64'd1);
        check_eq("t3_q0_drained", 64'(exp_q0.size()), 64'd0);

        // Backpressure on VC1.
        a_enq = 1'b1; a_enq_vc = 1'b1; a_int_vc = 1'b1; a_d_in = 64'hBEEF; a_ext_vc = 1'b0;
        settle();
        check_eq("t4_enq_ack", 64'(a_enq_ack), 64'd1);
        exp_q1.push_back(a_d_in);
        tick();
        a_enq = 1'b0; a_ext_vc = 1'b1; a_ro = 2'b00;
        for (int i = 0; i < 5; i++) begin
            settle();
            check_eq("t4_dout_held", a_dout, 64'hBEEF);
            check_eq("t4_so_stalled", 64'(a_so), 64'd0);
            check_eq("t4_count1", 64'(a_count[3:2]), 64'd1);
            tick();
        end
        a_ro = 2'b10;
        settle();
        check_eq("t4_so", 64'(a_so), 64'd1);
        tick();
        a_ro = 2'b00;
        settle();
        check_eq("t4_count1_after", 64'(a_count[3:2]), 64'd0);
        check_eq("t4_drop_sticky", 64'(a_drop), 64'd1);

        // Reset mid-stream with two flits queued on VC0.
        a_enq_vc = 1'b0; a_int_vc = 1'b0; a_ext_vc = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a_enq = 1'b1; a_d_in = 64'h66 + 64'(i);
            settle();
            check_eq("t1_enq_ack", 64'(a_enq_ack), 64'd1);
            exp_q0.push_back(a_d_in);
            tick();
        end
        a_enq = 1'b0; a_ro = 2'b01;
        settle();
        check_eq("t1_so_before", 64'(a_so), 64'd1);
        rst_n = 1'b0;
        settle();
        exp_q0.delete();
        check_eq("t1_so", 64'(a_so), 64'd0);
        check_eq("t1_dout", a_dout, 64'd0);
        check_eq("t1_empty", 64'(a_empty), 64'h3);
        check_eq("t1_count", 64'(a_count), 64'h0);
        check_eq("t1_drop", 64'(a_drop), 64'd0);
        a_ro = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Single VC, depth 3: fill, simultaneous write+send at full and at count 1.
        b_int_vc = 1'b0; b_ext_vc = 1'b0; b_enq_vc = 1'b0; b_ro = 1'b0;
        for (int i = 0; i < 3; i++) begin
            b_enq = 1'b1; b_d_in = 64'h40 + 64'(i);
            settle();
            check_eq("t5_fill_ack", 64'(b_enq_ack), 64'd1);
            exp_qb.push_back(b_d_in);
            tick();
        end
        b_enq = 1'b0;
        settle();
        check_eq("t5_full", 64'(b_full), 64'd1);
        check_eq("t5_count3", 64'(b_count), 64'd3);
        b_enq = 1'b1; b_d_in = 64'h44; b_ro = 1'b1;
        settle();
        check_eq("t5_full_ack", 64'(b_enq_ack), 64'd0);
        check_eq("t5_full_so", 64'(b_so), 64'd1);
        tick();
        b_enq = 1'b0; b_ro = 1'b0;
        settle();
        check_eq("t5_count2", 64'(b_count), 64'd2);
        check_eq("t5_drop", 64'(b_drop), 64'd1);
        b_ro = 1'b1;
        tick();
        b_enq = 1'b1; b_d_in = 64'h55;
        settle();
        check_eq("t5_count1_pre", 64'(b_count), 64'd1);
        check_eq("t5_c1_ack", 64'(b_enq_ack), 64'd1);
        check_eq("t5_c1_so", 64'(b_so), 64'd1);
        exp_qb.push_back(b_d_in);
        tick();
        b_enq = 1'b0; b_ro = 1'b0;
        settle();
        check_eq("t5_count1_post", 64'(b_count), 64'd1);

        // Out-of-range phase VC on the single-VC instance.
        b_enq = 1'b1; b_enq_vc = 1'b1; b_int_vc = 1'b1; b_d_in = 64'h99; b_ext_vc = 1'b1; b_ro = 1'b1;
        settle();
        check_eq("oor_ack", 64'(b_enq_ack), 64'd0);
        check_eq("oor_so", 64'(b_so), 64'd0);
        check_eq("oor_dout", b_dout, 64'd0);
        tick();
        b_enq = 1'b0; b_ro = 1'b0;
        settle();
        check_eq("oor_count", 64'(b_count), 64'd1);
        b_enq_vc = 1'b0; b_int_vc = 1'b0; b_ext_vc = 1'b0; b_ro = 1'b1;
        tick();
        b_ro = 1'b0;
        settle();
        check_eq("oor_drained", 64'(b_empty), 64'd1);

        // Stream 1..10 through depth 3 with random link stalls.
        rx_b = 0;
        next = 1;
        for (int cyc = 0; cyc < 300 && (next <= 10 || exp_qb.size() != 0); cyc++) begin
            b_ro = 1'($urandom_range(0, 1));
            b_enq = (next <= 10);
            b_d_in = 64'(next);
            settle();
            if (b_enq) begin
                check_eq("t6_enq_ack", 64'(b_enq_ack), 64'(exp_qb.size() < 3));
                if (exp_qb.size() < 3) begin
                    exp_qb.push_back(64'(next));
                    next++;
                end
            end
            tick();
        end
        b_enq = 1'b0; b_ro = 1'b0;
        settle();
        check_eq("t6_all_enqueued", 64'(next), 64'd11);
        check_eq("t6_rx_count", 64'(rx_b), 64'd10);
        check_eq("t6_empty", 64'(b_empty), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
